// File: rtl/memarb_if.sv
// Bus bundle between memarb, its two masters (m0 = CPU LSU, m1 = DMA/debug loader)
// and the single-ported data memory.
interface memarb_if;
  // Handshake: a master raises req with stable we/addr/wdata and holds it until
  // gnt pulses; gnt marks the one ACCESS cycle and rvalid the following RESP cycle,
  // where err and rdata are valid. Dropping req before gnt withdraws the request.
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m0_err;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        m1_err;

  logic        mem_MemWrite;
  logic        mem_MemRead;
  logic [31:0] mem_address;
  logic [31:0] mem_Write;
  logic [31:0] mem_Read;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_Read,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output mem_MemWrite, mem_MemRead, mem_address, mem_Write
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_Read,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  mem_MemWrite, mem_MemRead, mem_address, mem_Write
  );
endinterface

// File: rtl/memarb.sv
// Two-master arbiter/sequencer for the data memory: IDLE(latch) -> ACCESS -> RESP.
// Define MEMARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority to m0.
module memarb #(
  parameter int MEM_WORDS = 1024
) (
  input  logic       memarb_clk,
  input  logic       memarb_rst_n,
  memarb_if.slave    bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [31:0] mem_words_lim = 32'(MEM_WORDS);

  state_t      state;
  logic        win_id;
  logic        we_q;
  logic        err_q;
  logic        mem_we_q;
  logic        mem_re_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic        sel_id;
  logic        sel_we;
  logic        sel_err;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

`ifdef MEMARB_ROUND_ROBIN_EN
  logic        prio_q;  // master preferred on a tie
`endif

  always_comb begin
`ifdef MEMARB_ROUND_ROBIN_EN
    sel_id = (bus.m0_req && bus.m1_req) ? prio_q : !bus.m0_req;
`else
    sel_id = !bus.m0_req;
`endif
    sel_we    = sel_id ? bus.m1_we    : bus.m0_we;
    sel_addr  = sel_id ? bus.m1_addr  : bus.m0_addr;
    sel_wdata = sel_id ? bus.m1_wdata : bus.m0_wdata;
    sel_err   = (sel_addr[1:0] != 2'b00) || ({2'b00, sel_addr[31:2]} >= mem_words_lim);
  end

  always_ff @(posedge memarb_clk) begin
    if (!memarb_rst_n) begin
      state         <= IDLE;
      win_id        <= 1'b0;
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      bus.m0_gnt    <= 1'b0;
      bus.m1_gnt    <= 1'b0;
      bus.m0_rvalid <= 1'b0;
      bus.m1_rvalid <= 1'b0;
      bus.m0_err    <= 1'b0;
      bus.m1_err    <= 1'b0;
      bus.m0_rdata  <= '0;
      bus.m1_rdata  <= '0;
`ifdef MEMARB_ROUND_ROBIN_EN
      prio_q        <= 1'b0;
`endif
    end else begin
      bus.m0_gnt    <= 1'b0;
      bus.m1_gnt    <= 1'b0;
      bus.m0_rvalid <= 1'b0;
      bus.m1_rvalid <= 1'b0;
      bus.m0_err    <= 1'b0;
      bus.m1_err    <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      unique case (state)
        IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            state  <= ACCESS;
            win_id <= sel_id;
            we_q   <= sel_we;
            err_q  <= sel_err;
            if (sel_id) bus.m1_gnt <= 1'b1;
            else        bus.m0_gnt <= 1'b1;
            // Erroneous accesses never reach the memory lines.
            if (!sel_err) begin
              mem_we_q    <= sel_we;
              mem_re_q    <= !sel_we;
              mem_addr_q  <= sel_addr;
              mem_wdata_q <= sel_wdata;
            end
          end
        end
        ACCESS: begin
          state <= RESP;
          if (win_id) begin
            bus.m1_rvalid <= 1'b1;
            bus.m1_err    <= err_q;
            bus.m1_rdata  <= (err_q || we_q) ? '0 : bus.mem_Read;
          end else begin
            bus.m0_rvalid <= 1'b1;
            bus.m0_err    <= err_q;
            bus.m0_rdata  <= (err_q || we_q) ? '0 : bus.mem_Read;
          end
        end
        RESP: begin
          state <= IDLE;
`ifdef MEMARB_ROUND_ROBIN_EN
          prio_q <= !win_id;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Enables are gated by reset so a reset landing in ACCESS suppresses the store.
  assign bus.mem_MemWrite = mem_we_q & memarb_rst_n;
  assign bus.mem_MemRead  = mem_re_q & memarb_rst_n;
  assign bus.mem_address  = mem_addr_q;
  assign bus.mem_Write    = mem_wdata_q;
  assign dbg_state        = state;

endmodule

// File: tb/tb_memarb.sv
// Directed bench for memarb with a behavioural 1024-word memory model.
module tb_memarb;
  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         total;
  int         bad;

  logic [31:0] mem [0:1023];

  int m1_gnt_cnt;
  int m1_rv_cnt;
  int mem_en_cnt;
  int overlap_cnt;

  memarb_if bus ();

  memarb #(.MEM_WORDS(1024)) dut (
    .memarb_clk   (clk),
    .memarb_rst_n (rst_n),
    .bus          (bus),
    .dbg_state    (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: combinational read, write on rising edge
  assign bus.mem_Read = bus.mem_MemRead ? mem[bus.mem_address[11:2]] : 32'd0;
  always @(posedge clk) begin
    if (bus.mem_MemWrite) mem[bus.mem_address[11:2]] <= bus.mem_Write;
  end

  // activity monitor sampled 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    if (bus.m1_gnt) m1_gnt_cnt++;
    if (bus.m1_rvalid) m1_rv_cnt++;
    if (bus.mem_MemRead || bus.mem_MemWrite) mem_en_cnt++;
    if ((bus.m0_gnt && bus.m1_gnt) || (bus.m0_rvalid && bus.m1_rvalid) ||
        ((bus.m0_gnt || bus.m1_gnt) && (bus.m0_rvalid || bus.m1_rvalid)))
      overlap_cnt++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one transaction from IDLE and checks ACCESS, RESP and the return to IDLE.
  task automatic run_txn(input bit id, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit exp_err,
                         input logic [31:0] exp_rdata, input string tag);
    if (id) begin
      bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
    end else begin
      bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
    end
    tick();
    chk({tag, ".gnt"}, {30'd0, bus.m1_gnt, bus.m0_gnt}, id ? 32'd2 : 32'd1);
    chk({tag, ".st_access"}, {30'd0, dbg_state}, 32'd1);
    if (exp_err) begin
      chk({tag, ".en_err"}, {30'd0, bus.mem_MemWrite, bus.mem_MemRead}, 32'd0);
    end else begin
      chk({tag, ".en"}, {30'd0, bus.mem_MemWrite, bus.mem_MemRead}, we ? 32'd2 : 32'd1);
      chk({tag, ".addr"}, bus.mem_address, addr);
      if (we) chk({tag, ".wdata"}, bus.mem_Write, wdata);
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    tick();
    chk({tag, ".rvalid"}, {30'd0, bus.m1_rvalid, bus.m0_rvalid}, id ? 32'd2 : 32'd1);
    chk({tag, ".err"}, {31'd0, id ? bus.m1_err : bus.m0_err}, {31'd0, exp_err});
    chk({tag, ".rdata"}, id ? bus.m1_rdata : bus.m0_rdata, exp_rdata);
    chk({tag, ".idle_lines"}, {28'd0, bus.m0_gnt, bus.m1_gnt, bus.mem_MemWrite, bus.mem_MemRead}, 32'd0);
    tick();
    chk({tag, ".st_idle"}, {30'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    int m1_gnt_0, m1_rv_0, mem_en_0;
    logic exp_win;
    total = 0; bad = 0;
    m1_gnt_cnt = 0; m1_rv_cnt = 0; mem_en_cnt = 0; overlap_cnt = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    rst_n = 1'b0;
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
    tick();
    tick();

    // reset state
    chk("rst.state", {30'd0, dbg_state}, 32'd0);
    chk("rst.flags", {26'd0, bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.m0_err, bus.m1_err}, 32'd0);
    chk("rst.m0_rdata", bus.m0_rdata, 32'd0);
    chk("rst.m1_rdata", bus.m1_rdata, 32'd0);
    chk("rst.mem_en", {30'd0, bus.mem_MemWrite, bus.mem_MemRead}, 32'd0);
    chk("rst.mem_addr", bus.mem_address, 32'd0);
    rst_n = 1'b1;
    tick();

    // store then read back through the other master
    run_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, "st_m0");
    chk("st_m0.mem", mem[4], 32'hDEADBEEF);
    run_txn(1'b1, 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF, "ld_m1");

    // both masters hold load requests
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h10;
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 32'h14;
    for (int k = 0; k < 4; k++) begin
`ifdef MEMARB_ROUND_ROBIN_EN
      exp_win = k[0];
`else
      exp_win = 1'b0;
`endif
      tick();
      chk("arb.gnt", {30'd0, bus.m1_gnt, bus.m0_gnt}, exp_win ? 32'd2 : 32'd1);
      chk("arb.addr", bus.mem_address, exp_win ? 32'h14 : 32'h10);
      tick();
      chk("arb.rvalid", {30'd0, bus.m1_rvalid, bus.m0_rvalid}, exp_win ? 32'd2 : 32'd1);
      chk("arb.rdata", exp_win ? bus.m1_rdata : bus.m0_rdata, exp_win ? 32'd0 : 32'hDEADBEEF);
      tick();
    end
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
`ifndef MEMARB_ROUND_ROBIN_EN
    chk("arb.m1_rdata_hold", bus.m1_rdata, 32'hDEADBEEF);
`endif

    // address errors and the last legal word
    run_txn(1'b1, 1'b0, 32'h13, 32'd0, 1'b1, 32'd0, "err_misalign");
    run_txn(1'b1, 1'b0, 32'h1000, 32'd0, 1'b1, 32'd0, "err_range");
    run_txn(1'b1, 1'b1, 32'h1000, 32'h55AA55AA, 1'b1, 32'd0, "err_range_st");
    run_txn(1'b1, 1'b1, 32'hFFC, 32'hA5A5A5A5, 1'b0, 32'd0, "st_last");
    chk("st_last.mem", mem[1023], 32'hA5A5A5A5);
    run_txn(1'b0, 1'b0, 32'hFFC, 32'd0, 1'b0, 32'hA5A5A5A5, "ld_last");

    // reset during ACCESS suppresses the store
    run_txn(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 1'b0, 32'd0, "st_prior");
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 32'h20; bus.m0_wdata = 32'h12345678;
    tick();
    chk("rstacc.gnt", {31'd0, bus.m0_gnt}, 32'd1);
    rst_n = 1'b0;
    bus.m0_req = 1'b0;
    #1;
    chk("rstacc.we_gated", {31'd0, bus.mem_MemWrite}, 32'd0);
    tick();
    chk("rstacc.state", {30'd0, dbg_state}, 32'd0);
    chk("rstacc.flags", {26'd0, bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, bus.m0_err, bus.m1_err}, 32'd0);
    chk("rstacc.rdata", bus.m0_rdata | bus.m1_rdata, 32'd0);
    chk("rstacc.mem", {30'd0, bus.mem_MemWrite, bus.mem_MemRead} | bus.mem_address | bus.mem_Write, 32'd0);
    chk("rstacc.model", mem[8], 32'hCAFEF00D);
    rst_n = 1'b1;
    tick();
    chk("rstacc.no_rvalid", {30'd0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
    run_txn(1'b0, 1'b0, 32'h20, 32'd0, 1'b0, 32'hCAFEF00D, "ld_prior");

    // m1 pulses req while m0 owns the arbiter
    m1_gnt_0 = m1_gnt_cnt; m1_rv_0 = m1_rv_cnt; mem_en_0 = mem_en_cnt;
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 32'h10;
    tick();
    chk("drop.m0_gnt", {31'd0, bus.m0_gnt}, 32'd1);
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 32'h40; bus.m1_wdata = 32'h0BADF00D;
    tick();
    chk("drop.m0_rvalid", {31'd0, bus.m0_rvalid}, 32'd1);
    bus.m1_req = 1'b0;
    tick();
    tick();
    tick();
    chk("drop.state", {30'd0, dbg_state}, 32'd0);
    chk("drop.m1_gnt", m1_gnt_cnt - m1_gnt_0, 32'd0);
    chk("drop.m1_rvalid", m1_rv_cnt - m1_rv_0, 32'd0);
    chk("drop.mem_cycles", mem_en_cnt - mem_en_0, 32'd1);
    chk("drop.model", mem[16], 32'd0);

    chk("overlap", overlap_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/memarb.md
# memarb

Two-requester arbiter and sequencer for the single-ported word-addressed data memory. Master 0 is the CPU load/store unit and master 1 is the DMA/debug loader. The block latches one request at a time, drives the memory's write-enable, read-enable, address and write-data lines for exactly one cycle, captures the read data, and returns a one-cycle response to the winning master. It sits between both masters and the data memory; no other block drives the memory control lines.

## Interface
- `MEM_WORDS`, default 1024: number of 32-bit words in the attached memory; bounds the legal address range.
- `memarb_clk`  in  1  single clock; all state updates on rising edge.
- `memarb_rst_n`  in  1  reset, synchronous, active-low.
- `m0_req`, `m1_req`  in  1 each  request; held high with stable fields until the grant.
- `m0_we`, `m1_we`  in  1 each  1 = store, 0 = load.
- `m0_addr`, `m1_addr`  in  32 each  byte address; must be word-aligned.
- `m0_wdata`, `m1_wdata`  in  32 each  store data.
- `m0_gnt`, `m1_gnt`  out  1 each  one-cycle pulse: request accepted and executing.
- `m0_rvalid`, `m1_rvalid`  out  1 each  one-cycle response pulse, for both loads and stores.
- `m0_rdata`, `m1_rdata`  out  32 each  load data, valid with `rvalid`; 0 for stores and errors.
- `m0_err`, `m1_err`  out  1 each  error flag, valid with `rvalid`.
- `mem_MemWrite`  out  1  memory write enable.
- `mem_MemRead`  out  1  memory read enable.
- `mem_address`  out  32  memory byte address; the memory uses bits [31:2].
- `mem_Write`  out  32  memory write data.
- `mem_Read`  in  32  memory read data; combinational from the memory, and 0 when `mem_MemRead` = 0.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - No request pending: stay in IDLE.
  - One or more requests: select a winner (arbitration rule under Configuration).
  - Latch the winner's id, we, addr and wdata into internal registers, then go to ACCESS.
- Error check on the latched address: an error is raised when `addr[1:0]` ≠ 0 or `addr[31:2]` ≥ `MEM_WORDS`.
- ACCESS:
  - `gnt` of the winner is high.
  - Without error: `mem_MemWrite` = we, `mem_MemRead` = !we, and address/write-data come from the latched registers.
  - With error: both memory enables stay 0, so the memory is untouched.
  - A store commits at the rising edge that ends ACCESS.
  - For a load, `mem_Read` is captured into the winner's rdata register at that same edge.
  - Next state is RESP.
- RESP:
  - `rvalid` of the winner is high for one cycle; `err` shows the latched error.
  - Update the priority pointer, then go to IDLE.
- Outside ACCESS: `mem_MemWrite` = 0, `mem_MemRead` = 0, `mem_address` = 0, `mem_Write` = 0.
- The loser's request stays pending. It is served on the next IDLE evaluation.
- Dropping `req` before the grant cancels that request silently. Dropping it after the IDLE latch has no effect; the transaction completes.
- `rdata` of a master holds its value until that master's next load response. A store or error response sets it to 0.

## Timing
- Each transaction takes exactly 3 cycles: IDLE(latch) → ACCESS(grant, memory op) → RESP(rvalid).
- Peak throughput is one access per 3 cycles. The latency from `req` high in IDLE to `rvalid` is 2 cycles.
- Reset values: all `gnt`, `rvalid` and `err` = 0; all `rdata` = 0; all `mem_*` outputs = 0; state = IDLE; priority pointer = master 0.
- Reset asserted in ACCESS at the clock edge: the store is suppressed (reset has priority over the enable), no `rvalid` is produced, and the next state is IDLE.
- `gnt` and `rvalid` never assert for both masters in the same cycle.
- `gnt` and `rvalid` never assert in the same cycle.

## Configuration
- `MEMARB_ROUND_ROBIN_EN` defined:
  - Round-robin arbitration. The master that did not win last gets priority when both request.
  - The pointer flips only in RESP, to the non-winner.
- `MEMARB_ROUND_ROBIN_EN` not defined:
  - Fixed priority: master 0 always wins ties, and the pointer is unused.
  - Master 1 is served only in IDLE cycles where `m0_req` = 0.

## Test plan
- Reset, then m0 store addr 0x10 data 0xDEADBEEF → `m0_gnt` in cycle 2, `mem_MemWrite`=1, `mem_address`=0x10, `m0_rvalid` in cycle 3 with `m0_err`=0; then m1 load addr 0x10 → `m1_rdata`=0xDEADBEEF.
- m0 and m1 request loads in the same cycle, both held, flag defined → grant order m0, m1, m0, m1. Without the flag → m0 is granted every transaction and m1 never.
- m1 load addr 0x13 (misaligned), and separately addr 0x1000 with `MEM_WORDS`=1024 → `m1_err`=1, `m1_rdata`=0, `mem_MemRead`/`mem_MemWrite` stay 0 throughout.
- m0 store addr 0x20 data 0x12345678; `memarb_rst_n` driven low during ACCESS → a subsequent load of 0x20 returns the prior contents, all outputs are 0 in the cycle after reset, and the state is IDLE.
- m1 raises `req` for 1 cycle while m0 holds the arbiter; m1 drops `req` before being granted → no `m1_gnt`/`m1_rvalid`, and memory lines are driven only for m0's transaction.
